// File: rtl/conv_mac_window_if.sv
// conv_mac_window_if: handshake and operand/result bundle for conv_mac_window.
// The master side issues start, operand beats and out_ready.
// The slave side (the MAC engine) returns status, in_ready and the window result.
interface conv_mac_window_if #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 3,
  parameter int ACC_WIDTH  = 20
) ();
  logic                             start;
  logic                             busy;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_input;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_input;
  logic                             in_valid;
  logic                             in_ready;
  logic [BIT_LENGTH-1:0]            cSum;
  logic [ACC_WIDTH-1:0]             cSum_full;
  logic                             sat;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output start, multiplier_input, multiplicand_input, in_valid, out_ready,
    input  busy, in_ready, cSum, cSum_full, sat, out_valid
  );

  modport slave (
    input  start, multiplier_input, multiplicand_input, in_valid, out_ready,
    output busy, in_ready, cSum, cSum_full, sat, out_valid
  );
endinterface

// File: rtl/conv_mac_window.sv
// conv_mac_window: pipelined signed multiply-accumulate over one convolution window.
// Each beat carries PORT_COUNT operand pairs, and a window is KERNEL_LEN beats.
// Every product is summed into a single accumulator, and the result is returned over
// a valid/ready handshake.
// Build option CONV_SATURATE_EN: when it is defined, cSum is clamped to the signed
// BIT_LENGTH range and sat reports clamping. Otherwise cSum is the truncated low bits
// and sat is 0.
module conv_mac_window #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 3,
  parameter int KERNEL_LEN = 3,
  parameter int ACC_WIDTH  = 20
) (
  input logic              Clk,
  input logic              Rst,
  conv_mac_window_if.slave bus
);
  localparam int PROD_W = 2 * BIT_LENGTH;
  localparam int CNT_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERNEL_LEN - 1);

`ifdef CONV_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BIT_LENGTH+1){1'b0}}, {(BIT_LENGTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BIT_LENGTH+1){1'b1}}, {(BIT_LENGTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            beat_q, beat_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        s2_valid_q, s2_valid_d;
  logic signed [PROD_W-1:0]    mul_ext [PORT_COUNT];
  logic signed [PROD_W-1:0]    mcd_ext [PORT_COUNT];
  logic signed [PROD_W-1:0]    prod_q  [PORT_COUNT];
  logic signed [PROD_W-1:0]    prod_d  [PORT_COUNT];
  logic signed [ACC_WIDTH-1:0] tree_q, tree_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  // Stages 1 and 2: sign-extend the operands and form products, then add the registered products at accumulator width.
  always_comb begin
    tree_d = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      mul_ext[p] = {{BIT_LENGTH{bus.multiplier_input[p*BIT_LENGTH+BIT_LENGTH-1]}},
                    bus.multiplier_input[p*BIT_LENGTH +: BIT_LENGTH]};
      mcd_ext[p] = {{BIT_LENGTH{bus.multiplicand_input[p*BIT_LENGTH+BIT_LENGTH-1]}},
                    bus.multiplicand_input[p*BIT_LENGTH +: BIT_LENGTH]};
      prod_d[p]  = mul_ext[p] * mcd_ext[p];
      tree_d     = tree_d + ACC_WIDTH'(prod_q[p]);
    end
  end

  // Next-state logic, beat counting, stage valids and the stage 3 accumulate.
  // Leaving DRAIN when stage 1 is empty means that the last sum enters the accumulator on the same edge that enters DONE.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    s1_valid_d = 1'b0;
    s2_valid_d = s1_valid_q;
    acc_d      = acc_q;
    if (s2_valid_q) begin
      acc_d = acc_q + tree_q;
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LOAD;
          beat_d     = '0;
          s2_valid_d = 1'b0;
          acc_d      = '0;
        end
      end
      LOAD: begin
        s1_valid_d = bus.in_valid;
        if (bus.in_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decode and result narrowing. The result stays stable in DONE because the accumulator is idle there.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == DONE);
    bus.cSum_full = acc_q;
`ifdef CONV_SATURATE_EN
    bus.cSum = acc_q[BIT_LENGTH-1:0];
    bus.sat  = 1'b0;
    if (acc_q > SAT_MAX) begin
      bus.cSum = SAT_MAX[BIT_LENGTH-1:0];
      bus.sat  = (state_q == DONE);
    end else if (acc_q < SAT_MIN) begin
      bus.cSum = SAT_MIN[BIT_LENGTH-1:0];
      bus.sat  = (state_q == DONE);
    end
`else
    bus.cSum = acc_q[BIT_LENGTH-1:0];
    bus.sat  = 1'b0;
`endif
  end

  // State and pipeline registers. A low Rst aborts any window in progress.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      tree_q     <= '0;
      acc_q      <= '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        prod_q[p] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      tree_q     <= tree_d;
      acc_q      <= acc_d;
      for (int p = 0; p < PORT_COUNT; p++) begin
        prod_q[p] <= prod_d[p];
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_window.sv
// tb_conv_mac_window: directed self-checking bench for conv_mac_window with default parameters.
// The expected values are computed by hand for each window.
// The CONV_SATURATE_EN macro selects the expected narrowed result in the overflow case.
module tb_conv_mac_window;
  localparam int BIT_LENGTH = 8;
  localparam int PORT_COUNT = 3;
  localparam int KERNEL_LEN = 3;
  localparam int ACC_WIDTH  = 20;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   badCycles;
  logic [31:0] expOvfCsum;
  logic [31:0] expOvfSat;

  conv_mac_window_if #(
    .BIT_LENGTH(BIT_LENGTH),
    .PORT_COUNT(PORT_COUNT),
    .ACC_WIDTH (ACC_WIDTH)
  ) bus ();

  conv_mac_window #(
    .BIT_LENGTH(BIT_LENGTH),
    .PORT_COUNT(PORT_COUNT),
    .KERNEL_LEN(KERNEL_LEN),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // Free-running 10-unit clock.
  always #5 Clk = ~Clk;

  // Hard time limit, so that a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Run one window: every port gets the same operands on each beat.
  // g1 and g2 are the numbers of bubble cycles before beats 1 and 2.
  // The latency result counts the acceptance edge of the last beat as cycle 1.
  task automatic applyStimulus(input string tag,
                               input int m0, input int m1, input int m2,
                               input int c0, input int c1, input int c2,
                               input int g1, input int g2,
                               output int latency);
    int mv [3];
    int cv [3];
    int gap [3];
    mv  = '{m0, m1, m2};
    cv  = '{c0, c1, c2};
    gap = '{0, g1, g2};
    bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    checkOutput({tag, " in_ready after start"}, {31'b0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      repeat (gap[k]) begin
        bus.in_valid           = 1'b0;
        bus.multiplier_input   = {PORT_COUNT{8'h55}};
        bus.multiplicand_input = {PORT_COUNT{8'hAA}};
        @(posedge Clk); #1;
      end
      bus.multiplier_input   = {PORT_COUNT{mv[k][7:0]}};
      bus.multiplicand_input = {PORT_COUNT{cv[k][7:0]}};
      bus.in_valid           = 1'b1;
      @(posedge Clk); #1;
    end
    bus.in_valid = 1'b0;
    latency = 1;
    while (!bus.out_valid && latency < 20) begin
      @(posedge Clk); #1;
      latency++;
    end
  endtask

  task automatic finishWindow(input string tag);
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " busy after handshake"}, {31'b0, bus.busy}, 32'd0);
  endtask

  // Main directed sequence.
  initial begin
`ifdef CONV_SATURATE_EN
    expOvfCsum = 32'h7F;
    expOvfSat  = 32'd1;
`else
    expOvfCsum = 32'h09;
    expOvfSat  = 32'd0;
`endif
    bus.start              = 1'b0;
    bus.in_valid           = 1'b0;
    bus.out_ready          = 1'b0;
    bus.multiplier_input   = '0;
    bus.multiplicand_input = '0;

    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("reset in_ready",  {31'b0, bus.in_ready},  32'd0);
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset cSum",      {24'b0, bus.cSum},      32'd0);
    checkOutput("reset cSum_full", {12'b0, bus.cSum_full}, 32'd0);
    checkOutput("reset sat",       {31'b0, bus.sat},       32'd0);
    Rst = 1'b1;
    @(posedge Clk); #1;

    applyStimulus("basic", 1, 1, 1, 1, 1, 1, 0, 0, lat);
    checkOutput("basic latency",   lat,                    32'd3);
    checkOutput("basic cSum_full", {12'b0, bus.cSum_full}, 32'd9);
    checkOutput("basic cSum",      {24'b0, bus.cSum},      32'h09);
    checkOutput("basic sat",       {31'b0, bus.sat},       32'd0);
    finishWindow("basic");

    applyStimulus("signed", -2, -2, -2, 3, 3, 3, 0, 0, lat);
    checkOutput("signed latency",   lat,                    32'd3);
    checkOutput("signed cSum_full", {12'b0, bus.cSum_full}, 32'h000FFFCA);
    checkOutput("signed cSum",      {24'b0, bus.cSum},      32'hCA);
    checkOutput("signed sat",       {31'b0, bus.sat},       32'd0);
    finishWindow("signed");

    applyStimulus("overflow", 127, 127, 127, 127, 127, 127, 0, 0, lat);
    checkOutput("overflow cSum_full", {12'b0, bus.cSum_full}, 32'd145161);
    checkOutput("overflow cSum",      {24'b0, bus.cSum},      expOvfCsum);
    checkOutput("overflow sat",       {31'b0, bus.sat},       expOvfSat);
    finishWindow("overflow");

    applyStimulus("bubble", 1, 2, 3, 1, 2, 3, 2, 1, lat);
    checkOutput("bubble latency",   lat,                    32'd3);
    checkOutput("bubble cSum_full", {12'b0, bus.cSum_full}, 32'd42);
    finishWindow("bubble");

    applyStimulus("gapfree", 1, 2, 3, 1, 2, 3, 0, 0, lat);
    checkOutput("gapfree cSum_full", {12'b0, bus.cSum_full}, 32'd42);
    finishWindow("gapfree");

    applyStimulus("hold", 1, 1, 1, 1, 1, 1, 0, 0, lat);
    badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = (i % 2 == 0);
      @(posedge Clk); #1;
      if (!bus.out_valid || bus.cSum_full != 20'd9 || bus.cSum != 8'h09 || bus.in_ready) begin
        badCycles++;
      end
    end
    checkOutput("hold unstable cycles", badCycles, 32'd0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("hold busy after handshake", {31'b0, bus.busy}, 32'd0);
    @(posedge Clk); #1;
    checkOutput("hold start ignored busy",     {31'b0, bus.busy},     32'd0);
    checkOutput("hold start ignored in_ready", {31'b0, bus.in_ready}, 32'd0);

    bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start              = 1'b0;
    bus.multiplier_input   = {PORT_COUNT{8'd1}};
    bus.multiplicand_input = {PORT_COUNT{8'd1}};
    bus.in_valid           = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("abort partial cSum_full", {12'b0, bus.cSum_full}, 32'd6);
    Rst = 1'b0;
    @(posedge Clk); #1;
    checkOutput("abort busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("abort in_ready",  {31'b0, bus.in_ready},  32'd0);
    checkOutput("abort out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("abort cSum",      {24'b0, bus.cSum},      32'd0);
    checkOutput("abort cSum_full", {12'b0, bus.cSum_full}, 32'd0);
    checkOutput("abort sat",       {31'b0, bus.sat},       32'd0);
    Rst = 1'b1;
    badCycles = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (bus.out_valid || bus.busy) badCycles++;
    end
    checkOutput("abort no result", badCycles, 32'd0);
    applyStimulus("fresh", 1, 1, 1, 1, 1, 1, 0, 0, lat);
    checkOutput("fresh latency",   lat,                    32'd3);
    checkOutput("fresh cSum_full", {12'b0, bus.cSum_full}, 32'd9);
    finishWindow("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_mac_window.md
# conv_mac_window

Parametrised, pipelined multiply-accumulate engine for convolution windows; successor to the fixed-width three-port matrix accelerator path feeding the AXI convolution interface. Takes `PORT_COUNT` signed multiplier/multiplicand pairs per beat over `KERNEL_LEN` beats and sums every product into one accumulator. Returns the window result through a valid/ready handshake. Sits between the AXI register/stream front end and the result readback logic.

## Interface
- `BIT_LENGTH`, 8: operand width, signed two's complement.
- `PORT_COUNT`, 3: multiplier pairs per beat.
- `KERNEL_LEN`, 3: beats per window, ≥1.
- `ACC_WIDTH`, 20: accumulator width; must be ≥ 2*BIT_LENGTH + clog2(PORT_COUNT*KERNEL_LEN).
- `Clk` in 1: single clock, all logic on posedge.
- `Rst` in 1: synchronous, active-low reset.
- `start` in 1: begin a window; accepted only in IDLE.
- `busy` out 1: high in any state other than IDLE.
- `multiplier_input` in PORT_COUNT*BIT_LENGTH: flat operands, port 0 in LSBs.
- `multiplicand_input` in PORT_COUNT*BIT_LENGTH: flat operands, port 0 in LSBs.
- `in_valid` in 1: beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `cSum` out BIT_LENGTH: window result, narrowed from the accumulator.
- `cSum_full` out ACC_WIDTH: full accumulator.
- `sat` out 1: narrowing saturated; only driven when the saturation feature is compiled in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
  - IDLE → LOAD on `start`. Accumulator, beat counter and pipeline valids clear on that edge.
  - LOAD: `in_ready`=1. Each accepted beat increments the beat counter (0..KERNEL_LEN-1). LOAD → DRAIN on acceptance of beat KERNEL_LEN-1.
  - DRAIN: `in_ready`=0. Waits for the pipeline to empty, then goes to DONE.
  - DONE: `out_valid`=1 and outputs are held stable. DONE → IDLE on `out_ready`.
- Pipeline:
  - Stage 1 registers the PORT_COUNT signed products, 2*BIT_LENGTH each.
  - Stage 2 registers the sign-extended adder-tree sum at ACC_WIDTH.
  - Stage 3 adds that sum into the accumulator.
  - Each stage carries a valid bit, so `in_valid` gaps insert bubbles and do not corrupt the sum.
- Arithmetic:
  - All operations are signed, with sign extension at every widening step.
  - The accumulator wraps modulo 2^ACC_WIDTH; it cannot overflow when the parameter rule holds.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored.
- Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `cSum`=0, `cSum_full`=0, `sat`=0. State=IDLE and all pipeline valids are 0.
- Reset mid-window, in any state, aborts the window. No `out_valid` is produced for it.

## Timing
- `in_ready` rises the cycle after `start` is sampled in IDLE.
- Throughput: one beat per cycle, so a window completes in KERNEL_LEN cycles with no gaps.
- Latency: `out_valid` rises exactly 3 cycles after the cycle in which the final beat is accepted, independent of earlier bubbles.
- Earliest next `start`: the cycle after the `out_valid && out_ready` handshake, once the block is back in IDLE.
- If `start` is asserted in the same cycle as the DONE handshake, it is ignored.
- `out_ready` held low keeps the block in DONE indefinitely; no result is lost.

## Configuration
- Macro: `CONV_SATURATE_EN`.
- Defined:
  - `cSum` is `cSum_full` clamped to [-2^(BIT_LENGTH-1), 2^(BIT_LENGTH-1)-1].
  - `sat`=1 in DONE when clamping occurred.
- Undefined:
  - `cSum` = `cSum_full[BIT_LENGTH-1:0]` (plain truncation).
  - `sat` is tied to 0.
- `cSum_full` is identical in both builds.

## Test plan
All scenarios use the default parameters.
- Basic window: all operands 1, 3 beats back-to-back → `out_valid` 3 cycles after the last beat; `cSum_full`=9, `cSum`=0x09, `sat`=0.
- Signed values: multiplier -2, multiplicand 3 on all ports for 3 beats → `cSum_full`=-54, `cSum`=0xCA.
- Overflow: all operands 127 for 3 beats → `cSum_full`=145161.
  - With `CONV_SATURATE_EN`: `cSum`=0x7F, `sat`=1.
  - Without it: `cSum`=0x09, `sat`=0.
- Input bubbles: `in_valid` toggled 1,0,0,1,0,1 with operands 1..3 → sum equals the gap-free result; latency is measured from the last accepted beat.
- Backpressure and ignored start: `out_ready` held low 10 cycles while `start` pulses → `out_valid` and `cSum` stay stable; no new window begins; the block returns to IDLE after the handshake.
- Reset mid-window: `Rst`=0 after beat 1 → all outputs 0 the next cycle; a fresh window of all-1 operands then yields `cSum_full`=9.
